// File: rtl/hdub_core_debouncer_pkg.sv
// Shared types and constants for the board-input debouncer and its relatives.
package hdub_core_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } state_t;

  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/hdub_core_sync.sv
// N-flop single-bit synchroniser for asynchronous board inputs, with a
// configurable reset value so the chain starts at the expected idle level.
module hdub_core_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= {N{RESET_VAL}};
    else     r_chain <= {r_chain[N-2:0], i_d};
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/hdub_core_debouncer.sv
// Synchronises and debounces a raw board input into a clean level with
// one-cycle rise/fall pulses. Optional HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN adds glitch_cnt.
module hdub_core_debouncer
  import hdub_core_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4)
      $error("hdub_core_debouncer: SYNC_STAGES must be 2..4");
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 20))
      $error("hdub_core_debouncer: STABLE_CYCLES must be 2..2^20");
  endgenerate

  logic             w_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_out;
  logic             w_out_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             w_abort;

  hdub_core_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (in),
    .o_q (w_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_out   <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Entering a pend counts the first differing sample, so the commit happens
  // on the STABLE_CYCLES-th consecutive differing sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt = PEND_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PEND_HIGH: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = PEND_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PEND_LOW: begin
        if (w_s) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                  r_glitch_cnt <= '0;
    else if (w_abort && (r_glitch_cnt != '1)) r_glitch_cnt <= r_glitch_cnt + 1'b1;
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_hdub_core_debouncer.sv
// Directed bench: instance a (SYNC 2, STABLE 4, reset level 0) and instance b
// (SYNC 2, STABLE 2, reset level 1), checked per cycle against expected queues.
module tb_hdub_core_debouncer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst = 1'b1;
  logic a_in  = 1'b1;
  logic a_out, a_rise, a_fall;
  logic b_rst = 1'b1;
  logic b_in  = 1'b0;
  logic b_out, b_rise, b_fall;
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] a_glitch;
  logic [7:0] b_glitch;
`endif

  hdub_core_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .RESET_LEVEL   (1'b0)
  ) dut_a (
    .clk  (clk),
    .rst  (a_rst),
    .in   (a_in),
    .out  (a_out),
    .rise (a_rise),
    .fall (a_fall)
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    ,
    .glitch_cnt (a_glitch)
`endif
  );

  hdub_core_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (2),
    .RESET_LEVEL   (1'b1)
  ) dut_b (
    .clk  (clk),
    .rst  (b_rst),
    .in   (b_in),
    .out  (b_out),
    .rise (b_rise),
    .fall (b_fall)
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    ,
    .glitch_cnt (b_glitch)
`endif
  );

  // ---------------- scoreboard ----------------
  // Each entry is {out, rise, fall} expected just after the next rising edge.
  logic [2:0] exp_a_q[$];
  logic [2:0] exp_b_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int a_idx = 0;
  int b_idx = 0;

  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      n_checks++;
      if ({a_out, a_rise, a_fall} !== e) begin
        n_errors++;
        $display("FAIL dut_a step %0d: {out,rise,fall} got %b expected %b",
                 a_idx, {a_out, a_rise, a_fall}, e);
      end
      a_idx++;
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      n_checks++;
      if ({b_out, b_rise, b_fall} !== e) begin
        n_errors++;
        $display("FAIL dut_b step %0d: {out,rise,fall} got %b expected %b",
                 b_idx, {b_out, b_rise, b_fall}, e);
      end
      b_idx++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_a(input logic in_v, input logic rst_v, input logic [2:0] exp_v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_in  = in_v;
      a_rst = rst_v;
      exp_a_q.push_back(exp_v);
    end
  endtask

  task automatic step_b(input logic in_v, input logic rst_v, input logic [2:0] exp_v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_in  = in_v;
      b_rst = rst_v;
      exp_b_q.push_back(exp_v);
    end
  endtask

`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
  task automatic check_glitch(input logic [7:0] got, input logic [7:0] exp_v, input string name);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: glitch_cnt got %0d expected %0d", name, got, exp_v);
    end
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with in=1: outputs stay at the reset level.
    step_a(1'b1, 1'b1, 3'b000, 3);
    // Release: edges 0..1 synchronise, 4 counted samples, out rises on step 5.
    step_a(1'b1, 1'b0, 3'b000, 5);
    step_a(1'b1, 1'b0, 3'b110, 1);
    step_a(1'b1, 1'b0, 3'b100, 4);

    // Clean edges: fall, rise, fall with the same 6-step latency.
    step_a(1'b0, 1'b0, 3'b100, 5);
    step_a(1'b0, 1'b0, 3'b001, 1);
    step_a(1'b0, 1'b0, 3'b000, 4);
    step_a(1'b1, 1'b0, 3'b000, 5);
    step_a(1'b1, 1'b0, 3'b110, 1);
    step_a(1'b1, 1'b0, 3'b100, 4);
    step_a(1'b0, 1'b0, 3'b100, 5);
    step_a(1'b0, 1'b0, 3'b001, 1);
    step_a(1'b0, 1'b0, 3'b000, 4);
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    @(negedge clk);
    check_glitch(a_glitch, 8'd0, "clean_edges");
`endif

    // Bounce 1,0,1,1,0,0: two aborted pends, no output activity.
    step_a(1'b1, 1'b0, 3'b000, 1);
    step_a(1'b0, 1'b0, 3'b000, 1);
    step_a(1'b1, 1'b0, 3'b000, 2);
    step_a(1'b0, 1'b0, 3'b000, 6);
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    @(negedge clk);
    check_glitch(a_glitch, 8'd2, "bounce");
`endif

    // Bounce then settle: rise 5 steps after the final 0->1 step.
    step_a(1'b1, 1'b0, 3'b000, 1);
    step_a(1'b0, 1'b0, 3'b000, 1);
    step_a(1'b1, 1'b0, 3'b000, 5);
    step_a(1'b1, 1'b0, 3'b110, 1);
    step_a(1'b1, 1'b0, 3'b100, 3);
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    @(negedge clk);
    check_glitch(a_glitch, 8'd3, "bounce_settle");
`endif

    // Reset while pending low: out returns to 0 with no fall pulse.
    step_a(1'b0, 1'b0, 3'b100, 4);
    step_a(1'b0, 1'b1, 3'b000, 1);
    step_a(1'b0, 1'b0, 3'b000, 6);
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    @(negedge clk);
    check_glitch(a_glitch, 8'd0, "reset_clears_glitch");
`endif

    // Reset while pending high (cnt=2): pend discarded, full latency after release.
    step_a(1'b1, 1'b0, 3'b000, 4);
    step_a(1'b1, 1'b1, 3'b000, 1);
    step_a(1'b1, 1'b0, 3'b000, 5);
    step_a(1'b1, 1'b0, 3'b110, 1);
    step_a(1'b1, 1'b0, 3'b100, 2);

    // Instance b: reset level 1, STABLE_CYCLES 2 -> fall after 4 steps.
    step_b(1'b0, 1'b1, 3'b100, 2);
    step_b(1'b0, 1'b0, 3'b100, 3);
    step_b(1'b0, 1'b0, 3'b001, 1);
    step_b(1'b0, 1'b0, 3'b000, 2);

    // Reset back to high, then 300 single-sample dips, each an aborted pend.
    step_b(1'b1, 1'b1, 3'b100, 1);
    step_b(1'b1, 1'b0, 3'b100, 2);
    for (int k = 0; k < 300; k++) begin
      step_b(1'b0, 1'b0, 3'b100, 1);
      step_b(1'b1, 1'b0, 3'b100, 1);
    end
    step_b(1'b1, 1'b0, 3'b100, 4);
`ifdef HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN
    @(negedge clk);
    check_glitch(b_glitch, 8'd255, "glitch_saturation");
`endif

    // Drain: everything pushed must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending a=%0d b=%0d expected 0", exp_a_q.size(), exp_b_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hdub_core_debouncer.md
Name: hdub_core_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the thru-wire core.
- Takes a raw, asynchronous, bouncy 1-bit board input (switch or button) and synchronises it to `clk`.
- Filters out bounce and produces a clean level for the thru-wire core's `in`.
- Also emits single-cycle `rise` and `fall` pulses for edge-driven consumers.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the raw input; legal range 2..4.
- STABLE_CYCLES, 16, consecutive synchronised cycles the input must differ from `out` before `out` changes; legal range 2..2^20.
- RESET_LEVEL, 1'b0, value loaded into the synchroniser flops and `out` on reset.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  raw asynchronous input pin.
- out  output  1  debounced level; drives thru-wire `in`.
- rise  output  1  one-cycle pulse, high in the first cycle `out` reads 1 after being 0.
- fall  output  1  one-cycle pulse, high in the first cycle `out` reads 0 after being 1.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state, when `rst` is sampled high:
  - sync chain = RESET_LEVEL, `out` = RESET_LEVEL.
  - cnt = 0, `rise` = 0, `fall` = 0.
  - state = STABLE_HIGH if RESET_LEVEL is 1, else STABLE_LOW.
  - Reset has priority over all other events, including a pending transition on the same edge.
- Synchroniser: `s` = last flop of the SYNC_STAGES chain. It is the only signal the FSM reads.
- Counter: cnt width = $clog2(STABLE_CYCLES+1).
- FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
- STABLE_LOW:
  - `s`=1 → PEND_HIGH, cnt←1.
  - `s`=0 → stay, cnt←0.
- PEND_HIGH:
  - `s`=0 → STABLE_LOW, cnt←0 (aborted pend).
  - `s`=1 and cnt==STABLE_CYCLES-1 → STABLE_HIGH, `out`←1, `rise`←1, cnt←0.
  - `s`=1 otherwise → cnt←cnt+1.
- STABLE_HIGH and PEND_LOW mirror the above with polarity inverted; `fall` replaces `rise`.
- `out` is registered and changes only on a STABLE transition.
- Pulses are registered, high exactly one cycle, aligned with the first cycle of the new `out` value.
- Latency: a raw change held steady appears on `out` SYNC_STAGES+STABLE_CYCLES cycles after the first edge that samples it.
- Bounce shorter than STABLE_CYCLES synchronised cycles causes no `out` change and no pulse.
- `rise` and `fall` are never high in the same cycle.
- Counter never wraps; the maximum value reached is STABLE_CYCLES-1.
- Reset during PEND_*: pend is discarded; `out` = RESET_LEVEL the next cycle with no pulse.
- First sample after reset that differs from RESET_LEVEL starts a normal pend.
- Elaboration-time assertion: STABLE_CYCLES >= 2 and SYNC_STAGES >= 2.

Optional Feature:
- Macro: HDUB_CORE_DEBOUNCER_GLITCH_CNT_EN.
- Defined:
  - Adds output port `glitch_cnt` (8 bits).
  - Increments by 1 on every aborted pend (PEND_* → STABLE_* without an `out` change).
  - Saturates at 255; cleared to 0 by `rst`.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Package hdub_core_debouncer_pkg:
  - state enum: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW; 2-bit encoding.
  - GLITCH_CNT_W = 8 constant.
- Sub-module hdub_core_sync:
  - Parameterised N-flop synchroniser, width 1, with reset value parameter.
  - Reused by later board-input cores.
- FSM and counter stay in the top module.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0 unless stated):
- Reset: hold `in`=1 with `rst`=1 for 3 cycles → `out`=0, `rise`=`fall`=0 throughout; after release, `out`=1 exactly 6 cycles later and `rise`=1 for that single cycle.
- Clean edges: `in` 0→1, held 10 cycles, then 1→0 → `out` rises 6 cycles after the 0→1 edge and falls 6 cycles after the 1→0 edge; exactly one `rise` and one `fall`.
- Bounce: `in` pattern 1,0,1,1,0,0,… (never 4 consecutive synchronised 1s) → `out` stays 0, no pulses; with the macro, `glitch_cnt` = number of 0→1 runs (2).
- Bounce then settle: `in` 1,0,1 then held 1 → `out`=1 at 6 cycles after the final 0→1 edge; a single `rise` pulse.
- Reset mid-pend: `in`=1 for 4 cycles (cnt=2), `rst` pulsed for 1 cycle → `out`=0, no `rise`; with `in` still 1, `out` rises 6 cycles after `rst` deasserts.
- RESET_LEVEL=1, STABLE_CYCLES=2: `in`=0 held → `out` 1→0 at 4 cycles, `fall` pulse; glitch saturation check: 300 aborted pends → `glitch_cnt`=255.
